// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Fetch program counter with redirect priority, pending capture,
//            halt control and target alignment checking.
// Revision : 1.0
// ============================================================================
module pc_fetch_unit #(
   parameter int                 ADDR_W      = 32,
   parameter int                 INSTR_BYTES = 4,
   parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
   parameter logic [ADDR_W-1:0]  EXC_VEC     = ADDR_W'('h40)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              halt,
   input  logic              resume,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              exception,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   output logic [ADDR_W-1:0] pc_plus,
   output logic              misalign_err,
   output logic              halted
);

   localparam int                c_ALIGN_W = $clog2(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] c_INC     = ADDR_W'(INSTR_BYTES);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pend_target;
   logic              r_pend_valid;
   logic              r_outstanding;
   logic              r_misalign;

   logic              w_req_valid;
   logic              w_xfer;
   logic              w_hold;
   logic [ADDR_W-1:0] w_pc_plus;
   logic              w_jump_mis;
   logic              w_branch_mis;
   logic              w_redirect;
   logic              w_redir_mis;
   logic [ADDR_W-1:0] w_redir_target;
   logic [ADDR_W-1:0] w_xfer_target;

   generate
      if (c_ALIGN_W > 0) begin : g_align_chk
         assign w_jump_mis   = |jump_target[c_ALIGN_W-1:0];
         assign w_branch_mis = |branch_target[c_ALIGN_W-1:0];
      end else begin : g_no_align_chk
         assign w_jump_mis   = 1'b0;
         assign w_branch_mis = 1'b0;
      end
   endgenerate

   // A request once raised stays up until accepted, whatever stall does.
   assign w_req_valid = (r_state == S_RUN) && (r_outstanding || !stall);
   assign w_xfer      = w_req_valid && req_ready;
   assign w_hold      = w_req_valid && !req_ready;
   assign w_pc_plus   = r_pc + c_INC;

   always_comb begin
      w_redirect     = exception || jump || branch_taken;
      w_redir_mis    = 1'b0;
      w_redir_target = w_pc_plus;
      if (exception) begin
         w_redir_target = EXC_VEC;
      end else if (jump) begin
         w_redir_mis    = w_jump_mis;
         w_redir_target = w_jump_mis ? EXC_VEC : jump_target;
      end else if (branch_taken) begin
         w_redir_mis    = w_branch_mis;
         w_redir_target = w_branch_mis ? EXC_VEC : branch_target;
      end
   end

   always_comb begin
      w_xfer_target = w_pc_plus;
      if (w_redirect) begin
         w_xfer_target = w_redir_target;
      end else if (r_pend_valid) begin
         w_xfer_target = r_pend_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_VEC;
         r_pend_target <= RESET_VEC;
         r_pend_valid  <= 1'b0;
         r_outstanding <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_outstanding <= 1'b0;
         r_misalign    <= 1'b0;
         case (r_state)
            S_BOOT: begin
               r_state <= S_RUN;
               if (w_redirect) begin
                  r_pc       <= w_redir_target;
                  r_misalign <= w_redir_mis;
               end
            end
            S_RUN: begin
               r_outstanding <= w_hold;
               r_misalign    <= w_redirect && w_redir_mis;
               if (w_xfer) begin
                  r_pc         <= w_xfer_target;
                  r_pend_valid <= 1'b0;
               end else if (w_req_valid) begin
                  if (w_redirect) begin
                     r_pend_valid  <= 1'b1;
                     r_pend_target <= w_redir_target;
                  end
               end else if (w_redirect) begin
                  r_pc <= w_redir_target;
               end
               if (halt && !w_hold) begin
                  r_state <= S_HALT;
               end
            end
            S_HALT: begin
               if (exception) begin
                  r_pc    <= EXC_VEC;
                  r_state <= S_RUN;
               end else if (resume && !halt) begin
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_BOOT;
         endcase
      end
   end

   assign req_valid    = w_req_valid;
   assign req_addr     = r_pc;
   assign pc_plus      = w_pc_plus;
   assign misalign_err = r_misalign;
   assign halted       = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Vector table plus random-ready run against pc_fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_pc_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0;
   logic       halt = 1'b0;
   logic       resume = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_target = 8'h00;
   logic       jump = 1'b0;
   logic [7:0] jump_target = 8'h00;
   logic       exception = 1'b0;
   logic       req_valid;
   logic       req_ready = 1'b1;
   logic [7:0] req_addr;
   logic [7:0] pc_plus;
   logic       misalign_err;
   logic       halted;

   int n_cmp = 0;
   int n_bad = 0;

   pc_fetch_unit #(
      .ADDR_W      (8),
      .INSTR_BYTES (4),
      .RESET_VEC   (8'h00),
      .EXC_VEC     (8'h40)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .halt          (halt),
      .resume        (resume),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .exception     (exception),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .pc_plus       (pc_plus),
      .misalign_err  (misalign_err),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       chk;
      logic       rst_n, stall, halt, resume, exc, jmp;
      logic [7:0] jt;
      logic       br;
      logic [7:0] bt;
      logic       ready;
      logic       e_valid;
      logic [7:0] e_addr;
      logic       e_mis, e_halted;
   } vec_t;

   typedef struct {
      logic       valid;
      logic [7:0] addr;
      logic [7:0] plus;
      logic       mis;
      logic       hlt;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic vec_t mk(
      input logic chk, input logic rn, input logic st, input logic hl, input logic rs,
      input logic ex, input logic jp, input logic [7:0] jt, input logic br, input logic [7:0] bt,
      input logic rdy, input logic ev, input logic [7:0] ea, input logic em, input logic eh);
      vec_t v;
      v.chk = chk; v.rst_n = rn; v.stall = st; v.halt = hl; v.resume = rs;
      v.exc = ex; v.jmp = jp; v.jt = jt; v.br = br; v.bt = bt; v.ready = rdy;
      v.e_valid = ev; v.e_addr = ea; v.e_mis = em; v.e_halted = eh;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic compare_head(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         check({tag, " req_valid"},    {7'd0, req_valid},    {7'd0, e.valid});
         check({tag, " req_addr"},     req_addr,             e.addr);
         check({tag, " pc_plus"},      pc_plus,              e.plus);
         check({tag, " misalign_err"}, {7'd0, misalign_err}, {7'd0, e.mis});
         check({tag, " halted"},       {7'd0, halted},       {7'd0, e.hlt});
      end
   endtask

   initial begin
      exp_t       e;
      logic [7:0] exp_addr;
      logic       rdy;

      //        chk rn st hl rs ex jp jt     br bt     rdy  ev ea     em eh
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h00, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h04, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h08, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h0C, 0, 0));
      // Stalled handshake at 0x10 with a branch captured as pending
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h80, 0,   1, 8'h10, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h10, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h10, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h10, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 8'h20, 1, 8'h30, 1,   1, 8'h80, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 8'h20, 1, 8'h30, 1,   1, 8'h40, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 8'h22, 0, 8'h00, 1,   1, 8'h20, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h40, 1, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h44, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 8'h00, 1, 8'h60, 1,   0, 8'h44, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h60, 0, 0));
      // Halt / resume / exception-from-halt
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h64, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h68, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h68, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h68, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h6C, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h6C, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1,   0, 8'h70, 0, 1));
      // Wrap-around from 0xFC
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 8'hF8, 0, 8'h00, 1,   1, 8'h40, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hF8, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hFC, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 8'h20, 0, 8'h00, 1,   1, 8'h00, 0, 0));
      // Reset while outstanding with a pending redirect
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h20, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 8'h30, 0, 8'h00, 0,   1, 8'h24, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h24, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h00, 0, 0));
      // Misaligned pending branch, then overwritten by an aligned jump
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h41, 0,   1, 8'h04, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 8'h50, 0, 8'h00, 0,   1, 8'h04, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h04, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h50, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         rst_n         = tbl[i].rst_n;
         stall         = tbl[i].stall;
         halt          = tbl[i].halt;
         resume        = tbl[i].resume;
         exception     = tbl[i].exc;
         jump          = tbl[i].jmp;
         jump_target   = tbl[i].jt;
         branch_taken  = tbl[i].br;
         branch_target = tbl[i].bt;
         req_ready     = tbl[i].ready;
         if (tbl[i].chk) begin
            e.valid = tbl[i].e_valid;
            e.addr  = tbl[i].e_addr;
            e.plus  = tbl[i].e_addr + 8'd4;
            e.mis   = tbl[i].e_mis;
            e.hlt   = tbl[i].e_halted;
            sb.push_back(e);
         end
         @(negedge clk);
         if (tbl[i].chk) compare_head($sformatf("row%0d", i));
      end

      // Sequential fetch under random back-pressure, continuing after 0x50
      exp_addr = 8'h54;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
         exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
         rdy = 1'($urandom_range(0, 1));
         req_ready = rdy;
         e.valid = 1'b1;
         e.addr  = exp_addr;
         e.plus  = exp_addr + 8'd4;
         e.mis   = 1'b0;
         e.hlt   = 1'b0;
         sb.push_back(e);
         @(negedge clk);
         compare_head($sformatf("seq%0d", i));
         if (rdy) exp_addr = exp_addr + 8'd4;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter unit that supersedes the fixed 5-bit PC register, PC+4 incrementer and branch mux.
- Holds the fetch PC and issues one fetch request per accepted handshake to instruction memory.
- Selects the next PC from sequential, branch, jump or exception sources, with stall, halt and misalignment detection.
- Sits between decode/execute redirect logic and the instruction-memory port.

Parameters:
- ADDR_W, 32: PC / address width in bits (minimum 4).
- INSTR_BYTES, 4: sequential increment; power of two, at least 1.
- RESET_VEC, 0: PC value loaded on reset.
- EXC_VEC, 'h40: PC loaded on exception or misaligned redirect.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hold PC; suppress new requests.
- halt  in  1  enter HALT state.
- resume  in  1  leave HALT state.
- branch_taken  in  1  branch redirect request.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  jump redirect request.
- jump_target  in  ADDR_W  jump destination.
- exception  in  1  redirect to EXC_VEC.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  imem accepts request.
- req_addr  out  ADDR_W  fetch address (current PC).
- pc_plus  out  ADDR_W  req_addr + INSTR_BYTES, wraps modulo 2^ADDR_W.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: when rst_n=0 at posedge, the next state is BOOT. Reset values: PC=RESET_VEC, req_valid=0, misalign_err=0, halted=0, pending redirect cleared. Reset wins over all other inputs, including mid-handshake; any in-flight request is dropped.
- States:
  - BOOT: one cycle, req_valid=0, then unconditionally go to RUN.
  - RUN: req_valid = !stall, or a request is outstanding.
  - HALT: req_valid=0, halted=1.
- Handshake:
  - A transfer occurs when req_valid && req_ready.
  - Once req_valid is asserted, req_addr and req_valid are held stable until the transfer, regardless of stall or halt.
  - No combinational path from req_ready to req_valid.
- Next PC on a transfer, in priority order:
  1. Exception → EXC_VEC.
  2. Jump → jump_target.
  3. Branch → branch_target.
  4. Pending redirect.
  5. Otherwise pc_plus.
- Redirect with no outstanding request: the PC is updated on that clock edge, even if stall=1.
- Redirect while a request is outstanding and not yet accepted: capture it into the pending register, resolved with the same priority. A later redirect overwrites the pending one. The pending target is applied on the transfer edge; clear pending on use.
- Alignment check:
  - A jump or branch target with addr[log2(INSTR_BYTES)-1:0] ≠ 0 is misaligned.
  - Substitute EXC_VEC as the target.
  - Pulse misalign_err for exactly one cycle, the cycle after detection.
  - EXC_VEC itself is not checked.
- Halt:
  - halt=1 in RUN → HALT once no request is outstanding; otherwise after the transfer completes.
  - resume=1 in HALT → RUN next cycle; PC unchanged.
  - halt and resume asserted together: halt wins.
  - An exception in HALT loads EXC_VEC and goes to RUN.
- Stall with no outstanding request: PC holds and req_valid=0.
- Wrap-around: PC at 2^ADDR_W - INSTR_BYTES advances to 0.
- Latency: a redirect seen at edge N appears on req_addr after edge N (same edge, registered). Throughput is one fetch per cycle with req_ready held high.

Test Plan (ADDR_W=8, INSTR_BYTES=4, RESET_VEC=0x00, EXC_VEC=0x40):
- Reset with req_ready=1, no redirects → BOOT for one cycle, then req_addr = 0x00, 0x04, 0x08, … one per cycle. Checks: pc_plus = req_addr+4; 0xFC wraps to 0x00.
- Drive req_ready=0 for 3 cycles with req_addr=0x10 and branch_taken=1, target 0x80, on cycle 1 → req_addr stays 0x10 and req_valid stays 1. After the transfer, next req_addr = 0x80.
- Same edge: exception=1, jump to 0x20, branch to 0x30 → next PC 0x40. Same edge without exception → 0x20.
- Jump to 0x22 → next req_addr 0x40 and one-cycle misalign_err pulse.
- Sequence halt → halted=1, req_valid=0, PC held; resume → fetching continues from the held PC. Exception while halted → req_addr 0x40.
- rst_n=0 while a request is outstanding at 0x24 and a redirect is pending → req_valid=0 next cycle. Then BOOT, then fetch from 0x00; the pending redirect is discarded.
